controle_temporizador_rodadas: RTL and testbench

Sequencing controller for the saturating timeout counter `contador_m_trava` in a reaction-time game datapath. The controller runs a sequence of `RODADAS` rounds and drives the counter's synchronous clear and count-enable. In each round it waits for a player event before the counter saturates. It reports the number of hits and whether the sequence ended by timeout, and it sits between the top-level FSM (start/done handshake) and the counter instance.

---
 rtl/controle_temporizador_rodadas.sv | 167 ++++++++++++++++
 tb/tb_controle_temporizador_rodadas.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_temporizador_rodadas.sv
// -----------------------------------------------------------------------------
// controle_temporizador_rodadas
//
// Sequencing controller for the saturating timeout counter contador_m_trava in
// a reaction-time game. It runs RODADAS rounds. In each round it clears the
// counter, lets it count, and waits for a player event before the counter
// saturates. It reports the current round, the number of hits, and whether
// the sequence ended by timeout.
//
// Optional feature macro: ALERTA_MEIO_EN
//   defined   -> alerta is a registered half-window warning raised by meio_t
//                while waiting in espera.
//   undefined -> alerta is tied to 0. The port is still present.
//
// Parameters
//   RODADAS  rounds per sequence, 1 .. 2**W-1
//   W        width of rodada / acertos (2**W > RODADAS)
//
// Ports
//   clock      in   system clock, rising edge
//   zera_as_n  in   asynchronous active-low reset
//   iniciar    in   start request, sampled in inicial / final_* only
//   evento     in   raw player event level; its rising edge is a hit
//   fim_t      in   counter saturated (timeout)
//   meio_t     in   counter at half window
//   zera_t     out  synchronous clear to the counter
//   conta_t    out  count enable to the counter
//   rodada     out  current round index, 0-based
//   acertos    out  hits in the current or last sequence
//   ocupado    out  sequence in progress
//   pronto     out  one-cycle pulse on entry to final_ok / final_timeout
//   timeout    out  sequence ended by timeout (held until next start)
//   alerta     out  half-window warning
//   db_estado  out  state code, for debug
//
// Handshake: iniciar is a level request. It is accepted on any clock edge
// where the FSM sits in inicial or a final state; completion is reported by
// the single-cycle pronto pulse, with timeout qualifying how it ended.
// -----------------------------------------------------------------------------
module controle_temporizador_rodadas #(
   parameter int RODADAS = 16,
   parameter int W       = 5
) (
   input  logic         clock,
   input  logic         zera_as_n,
   input  logic         iniciar,
   input  logic         evento,
   input  logic         fim_t,
   input  logic         meio_t,
   output logic         zera_t,
   output logic         conta_t,
   output logic [W-1:0] rodada,
   output logic [W-1:0] acertos,
   output logic         ocupado,
   output logic         pronto,
   output logic         timeout,
   output logic         alerta,
   output logic [3:0]   db_estado
);

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      PREPARACAO    = 4'd1,
      ESPERA        = 4'd2,
      REGISTRA      = 4'd3,
      PROXIMA       = 4'd4,
      FINAL_OK      = 4'd5,
      FINAL_TIMEOUT = 4'd6
   } estado_t;

   localparam logic [W-1:0] ULTIMA_RODADA = W'(RODADAS - 1);
   localparam logic [W-1:0] MAX_ACERTOS   = W'(RODADAS);

   estado_t        estado_q;
   logic [W-1:0]   rodada_q;
   logic [W-1:0]   acertos_q;
   logic           evento_d_q;
   logic           pronto_q;
   logic           ev;

   // A held evento counts once: only the 0->1 transition is a hit.
   assign ev = evento & ~evento_d_q;

   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         estado_q   <= INICIAL;
         rodada_q   <= '0;
         acertos_q  <= '0;
         evento_d_q <= 1'b0;
         pronto_q   <= 1'b0;
      end else begin
         evento_d_q <= evento;
         pronto_q   <= 1'b0;
         case (estado_q)
            INICIAL: begin
               if (iniciar) estado_q <= PREPARACAO;
            end
            PREPARACAO: begin
               rodada_q  <= '0;
               acertos_q <= '0;
               estado_q  <= ESPERA;
            end
            ESPERA: begin
               // A hit in the same cycle as saturation still counts.
               if (ev) begin
                  estado_q <= REGISTRA;
               end else if (fim_t) begin
                  estado_q <= FINAL_TIMEOUT;
                  pronto_q <= 1'b1;
               end
            end
            REGISTRA: begin
               if (acertos_q < MAX_ACERTOS) acertos_q <= acertos_q + 1'b1;
               estado_q <= PROXIMA;
            end
            PROXIMA: begin
               if (rodada_q == ULTIMA_RODADA) begin
                  estado_q <= FINAL_OK;
                  pronto_q <= 1'b1;
               end else begin
                  rodada_q <= rodada_q + 1'b1;
                  estado_q <= ESPERA;
               end
            end
            FINAL_OK, FINAL_TIMEOUT: begin
               if (iniciar) estado_q <= PREPARACAO;
            end
            default: estado_q <= INICIAL;
         endcase
      end
   end

   // Moore decodes: state register only.
   assign zera_t    = (estado_q == INICIAL) || (estado_q == PREPARACAO) ||
                      (estado_q == REGISTRA);
   assign conta_t   = (estado_q == ESPERA);
   assign ocupado   = !((estado_q == INICIAL) || (estado_q == FINAL_OK) ||
                        (estado_q == FINAL_TIMEOUT));
   assign timeout   = (estado_q == FINAL_TIMEOUT);
   assign db_estado = estado_q;
   assign rodada    = rodada_q;
   assign acertos   = acertos_q;
   assign pronto    = pronto_q;

`ifdef ALERTA_MEIO_EN
   logic alerta_q;

   // Sticky while the FSM stays in espera; leaving espera (hit or timeout)
   // clears it on the same edge.
   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         alerta_q <= 1'b0;
      end else if ((estado_q == ESPERA) && !ev && !fim_t) begin
         alerta_q <= alerta_q | meio_t;
      end else begin
         alerta_q <= 1'b0;
      end
   end

   assign alerta = alerta_q;
`else
   logic unused_meio;
   assign unused_meio = meio_t;
   assign alerta      = 1'b0;
`endif

endmodule

// File: tb/tb_controle_temporizador_rodadas.sv
module tb_controle_temporizador_rodadas;

   localparam int RODADAS = 4;
   localparam int W       = 5;
   localparam int M       = 10;

   localparam logic [3:0] S_INICIAL  = 4'd0;
   localparam logic [3:0] S_PREP     = 4'd1;
   localparam logic [3:0] S_ESPERA   = 4'd2;
   localparam logic [3:0] S_REGISTRA = 4'd3;
   localparam logic [3:0] S_PROXIMA  = 4'd4;
   localparam logic [3:0] S_FIM_OK   = 4'd5;
   localparam logic [3:0] S_FIM_TO   = 4'd6;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic zera_as_n = 1'b1;
   always #5 clock = ~clock;

   logic         iniciar = 1'b0;
   logic         evento  = 1'b0;
   logic         fim_t;
   logic         meio_t;
   logic         zera_t;
   logic         conta_t;
   logic [W-1:0] rodada;
   logic [W-1:0] acertos;
   logic         ocupado;
   logic         pronto;
   logic         timeout;
   logic         alerta;
   logic [3:0]   db_estado;

   int vectors   = 0;
   int errors    = 0;
   int pronto_cnt = 0;

   controle_temporizador_rodadas #(.RODADAS(RODADAS), .W(W)) dut (
      .clock     (clock),
      .zera_as_n (zera_as_n),
      .iniciar   (iniciar),
      .evento    (evento),
      .fim_t     (fim_t),
      .meio_t    (meio_t),
      .zera_t    (zera_t),
      .conta_t   (conta_t),
      .rodada    (rodada),
      .acertos   (acertos),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .timeout   (timeout),
      .alerta    (alerta),
      .db_estado (db_estado)
   );

   // Environment model of contador_m_trava: saturating 0..M-1 counter.
   int cnt = 0;
   always @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n)             cnt <= 0;
      else if (zera_t)            cnt <= 0;
      else if (conta_t && cnt < M-1) cnt <= cnt + 1;
   end
   assign fim_t  = (cnt == M-1);
   assign meio_t = (cnt == M/2-1);

   always @(negedge clock) if (pronto === 1'b1) pronto_cnt++;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget);
      int n = 0;
      while (db_estado !== s && n < budget) begin tick(); n++; end
      vectors++;
      if (db_estado !== s) begin
         errors++;
         $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", db_estado, s, budget);
      end
   endtask

   task automatic start_seq();
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      vectors++; if (db_estado !== S_PREP) begin errors++; $display("FAIL start_prep: got %0d expected 1", db_estado); end
      vectors++; if (zera_t !== 1'b1 || ocupado !== 1'b1) begin errors++; $display("FAIL start_prep_dec: got zera_t=%0b ocupado=%0b expected 1 1", zera_t, ocupado); end
      tick();
      vectors++; if (db_estado !== S_ESPERA) begin errors++; $display("FAIL start_espera: got %0d expected 2", db_estado); end
      vectors++; if (conta_t !== 1'b1 || zera_t !== 1'b0) begin errors++; $display("FAIL start_espera_dec: got conta_t=%0b zera_t=%0b expected 1 0", conta_t, zera_t); end
      vectors++; if (rodada !== 0 || acertos !== 0) begin errors++; $display("FAIL start_clear: got rodada=%0d acertos=%0d expected 0 0", rodada, acertos); end
   endtask

   // One hit 3 cycles into espera; leaves the FSM in proxima.
   task automatic hit_round(input int r);
      wait_state(S_ESPERA, 20);
      vectors++; if (rodada !== W'(r)) begin errors++; $display("FAIL hit_rodada: got %0d expected %0d", rodada, r); end
      repeat (3) tick();
      evento = 1'b1; tick(); evento = 1'b0;
      vectors++; if (db_estado !== S_REGISTRA || zera_t !== 1'b1) begin errors++; $display("FAIL hit_registra: got state=%0d zera_t=%0b expected 3 1", db_estado, zera_t); end
      tick();
      vectors++; if (db_estado !== S_PROXIMA) begin errors++; $display("FAIL hit_proxima: got %0d expected 4", db_estado); end
      vectors++; if (acertos !== W'(r+1)) begin errors++; $display("FAIL hit_acertos: got %0d expected %0d", acertos, r+1); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 zera_as_n = 1'b0; #1;
      vectors++; if (db_estado !== S_INICIAL) begin errors++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
      vectors++; if (zera_t !== 1'b1 || conta_t !== 1'b0) begin errors++; $display("FAIL reset_counter_ctl: got zera_t=%0b conta_t=%0b expected 1 0", zera_t, conta_t); end
      vectors++; if (ocupado !== 1'b0 || timeout !== 1'b0 || pronto !== 1'b0 || alerta !== 1'b0) begin errors++; $display("FAIL reset_flags: got ocupado=%0b timeout=%0b pronto=%0b alerta=%0b expected 0 0 0 0", ocupado, timeout, pronto, alerta); end
      vectors++; if (rodada !== 0 || acertos !== 0) begin errors++; $display("FAIL reset_counts: got rodada=%0d acertos=%0d expected 0 0", rodada, acertos); end
      repeat (2) tick();
      zera_as_n = 1'b1;
      repeat (3) tick();
      vectors++; if (db_estado !== S_INICIAL) begin errors++; $display("FAIL reset_idle: got %0d expected 0", db_estado); end
   endtask

   task automatic test_full_hits();
      pronto_cnt = 0;
      start_seq();
      for (int r = 0; r < RODADAS; r++) hit_round(r);
      tick();
      vectors++; if (db_estado !== S_FIM_OK) begin errors++; $display("FAIL full_estado: got %0d expected 5", db_estado); end
      vectors++; if (pronto !== 1'b1) begin errors++; $display("FAIL full_pronto: got %0b expected 1", pronto); end
      tick();
      vectors++; if (pronto !== 1'b0) begin errors++; $display("FAIL full_pronto_pulse: got %0b expected 0", pronto); end
      vectors++; if (acertos !== 4 || rodada !== 3) begin errors++; $display("FAIL full_counts: got acertos=%0d rodada=%0d expected 4 3", acertos, rodada); end
      vectors++; if (timeout !== 1'b0 || ocupado !== 1'b0 || zera_t !== 1'b0 || conta_t !== 1'b0) begin errors++; $display("FAIL full_flags: got timeout=%0b ocupado=%0b zera_t=%0b conta_t=%0b expected 0 0 0 0", timeout, ocupado, zera_t, conta_t); end
      repeat (3) tick();
      vectors++; if (pronto_cnt !== 1 || db_estado !== S_FIM_OK) begin errors++; $display("FAIL full_single_pronto: got pronto_cnt=%0d state=%0d expected 1 5", pronto_cnt, db_estado); end
   endtask

   task automatic test_back_to_back();
      pronto_cnt = 0;
      iniciar = 1'b1;
      tick();
      vectors++; if (db_estado !== S_PREP) begin errors++; $display("FAIL b2b_prep: got %0d expected 1", db_estado); end
      tick();
      vectors++; if (db_estado !== S_ESPERA) begin errors++; $display("FAIL b2b_espera: got %0d expected 2", db_estado); end
      vectors++; if (acertos !== 0 || rodada !== 0) begin errors++; $display("FAIL b2b_clear: got acertos=%0d rodada=%0d expected 0 0", acertos, rodada); end
      tick(); iniciar = 1'b0;
      vectors++; if (db_estado !== S_ESPERA || pronto_cnt !== 0) begin errors++; $display("FAIL b2b_hold: got state=%0d pronto_cnt=%0d expected 2 0", db_estado, pronto_cnt); end
   endtask

   task automatic test_reset_mid();
      hit_round(0);
      wait_state(S_ESPERA, 5);
      repeat (3) tick();
      vectors++; if (acertos !== 1 || rodada !== 1) begin errors++; $display("FAIL mid_before: got acertos=%0d rodada=%0d expected 1 1", acertos, rodada); end
      pronto_cnt = 0;
      #2 zera_as_n = 1'b0; #1;
      vectors++; if (db_estado !== S_INICIAL || zera_t !== 1'b1) begin errors++; $display("FAIL mid_estado: got state=%0d zera_t=%0b expected 0 1", db_estado, zera_t); end
      vectors++; if (acertos !== 0 || rodada !== 0 || pronto !== 1'b0) begin errors++; $display("FAIL mid_counts: got acertos=%0d rodada=%0d pronto=%0b expected 0 0 0", acertos, rodada, pronto); end
      repeat (2) tick();
      zera_as_n = 1'b1;
      repeat (4) tick();
      vectors++; if (db_estado !== S_INICIAL || pronto_cnt !== 0) begin errors++; $display("FAIL mid_no_pronto: got state=%0d pronto_cnt=%0d expected 0 0", db_estado, pronto_cnt); end
   endtask

   task automatic test_timeout();
      pronto_cnt = 0;
      start_seq();
      hit_round(0);
      hit_round(1);
      tick();
      vectors++; if (db_estado !== S_ESPERA || rodada !== 2) begin errors++; $display("FAIL to_round2: got state=%0d rodada=%0d expected 2 2", db_estado, rodada); end
      repeat (4) tick();
      vectors++; if (alerta !== 1'b0) begin errors++; $display("FAIL to_alerta_pre: got %0b expected 0", alerta); end
      tick();
`ifdef ALERTA_MEIO_EN
      vectors++; if (alerta !== 1'b1) begin errors++; $display("FAIL to_alerta_set: got %0b expected 1", alerta); end
`else
      vectors++; if (alerta !== 1'b0) begin errors++; $display("FAIL to_alerta_off: got %0b expected 0", alerta); end
`endif
      repeat (4) tick();
      vectors++; if (db_estado !== S_ESPERA || fim_t !== 1'b1) begin errors++; $display("FAIL to_last_wait: got state=%0d fim_t=%0b expected 2 1", db_estado, fim_t); end
      tick();
      vectors++; if (db_estado !== S_FIM_TO || timeout !== 1'b1 || pronto !== 1'b1) begin errors++; $display("FAIL to_final: got state=%0d timeout=%0b pronto=%0b expected 6 1 1", db_estado, timeout, pronto); end
      vectors++; if (acertos !== 2 || rodada !== 2 || alerta !== 1'b0) begin errors++; $display("FAIL to_counts: got acertos=%0d rodada=%0d alerta=%0b expected 2 2 0", acertos, rodada, alerta); end
      repeat (3) tick();
      vectors++; if (timeout !== 1'b1 || pronto_cnt !== 1 || ocupado !== 1'b0) begin errors++; $display("FAIL to_hold: got timeout=%0b pronto_cnt=%0d ocupado=%0b expected 1 1 0", timeout, pronto_cnt, ocupado); end
   endtask

   task automatic test_simultaneous();
      start_seq();
      vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL sim_restart_timeout: got %0b expected 0", timeout); end
      repeat (M-1) tick();
      vectors++; if (fim_t !== 1'b1 || db_estado !== S_ESPERA) begin errors++; $display("FAIL sim_setup: got fim_t=%0b state=%0d expected 1 2", fim_t, db_estado); end
      evento = 1'b1; tick(); evento = 1'b0;
      vectors++; if (db_estado !== S_REGISTRA || timeout !== 1'b0) begin errors++; $display("FAIL sim_priority: got state=%0d timeout=%0b expected 3 0", db_estado, timeout); end
      repeat (2) tick();
      vectors++; if (db_estado !== S_ESPERA || acertos !== 1 || rodada !== 1) begin errors++; $display("FAIL sim_counted: got state=%0d acertos=%0d rodada=%0d expected 2 1 1", db_estado, acertos, rodada); end
   endtask

   task automatic test_held_event();
      #2 zera_as_n = 1'b0; tick(); zera_as_n = 1'b1; tick();
      pronto_cnt = 0;
      start_seq();
      evento = 1'b1;
      repeat (20) tick();
      evento = 1'b0;
      vectors++; if (acertos !== 1 || rodada !== 1) begin errors++; $display("FAIL held_once: got acertos=%0d rodada=%0d expected 1 1", acertos, rodada); end
      vectors++; if (db_estado !== S_FIM_TO || pronto_cnt !== 1) begin errors++; $display("FAIL held_timeout: got state=%0d pronto_cnt=%0d expected 6 1", db_estado, pronto_cnt); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_full_hits();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      test_simultaneous();
      test_held_event();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
